// File: rtl/mmio_uart_tx.sv
// Store-mapped UART transmitter: TX-address byte stores are queued in a FIFO and sent 8N1, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'h0000_FFF0,
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_FFF4,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWriteM,
  input  logic [31:0]                   DataAdrM,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_PARITY_EN
  logic          r_parity;
`endif

  logic       w_tx_store;
  logic       w_ctrl_store;
  logic       w_full;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_flush;
  logic       w_clr_ovf;
  logic       w_bit_end;
  logic [7:0] w_head;
  logic       w_unused;

  // Handshakes: the store side has no ready -- a TX store is taken when a slot is free
  // (or freed by a pop on the same edge) and dropped otherwise. The pop side is
  // valid = (count != 0), ready = FSM in IDLE; a pop happens on the edge where both hold.
  assign w_tx_store   = MemWriteM && (DataAdrM == TX_ADDR);
  assign w_ctrl_store = MemWriteM && (DataAdrM == CTRL_ADDR);
  assign w_full       = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_pop        = (r_state == S_IDLE) && (r_count != '0);
  assign w_push       = w_tx_store && (!w_full || w_pop);
  assign w_drop       = w_tx_store && w_full && !w_pop;
  assign w_flush      = w_ctrl_store && WriteData[1];
  assign w_clr_ovf    = w_ctrl_store && WriteData[0];
  assign w_bit_end    = (r_baud == CW'(CLKS_PER_BIT - 1));
  assign w_head       = r_mem[r_rd_ptr];
  assign w_unused     = ^WriteData[31:8];

  // Storage is not reset; a reset or flush discards contents by clearing the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (PW+1)'(1);
          2'b01:   r_count <= r_count - (PW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
      // A drop on the same edge as a clear request leaves the flag set.
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_clr_ovf) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= S_START;
            r_tx    <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity <= ^w_head;
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
`endif
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8): vector table plus
// hand-written reset, overflow, flush and wrap-around sequences with a serial receiver.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteData;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        frame;
    logic        par;
  } vec_t;

  vec_t vecs[9];

  mmio_uart_tx #(
    .TX_ADDR     (32'h0000_FFF0),
    .CTRL_ADDR   (32'h0000_FFF4),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWriteM (MemWriteM),
    .DataAdrM  (DataAdrM),
    .WriteData (WriteData),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; the store is sampled at the following posedge, returns at the next negedge.
  task automatic store(input logic we, input logic [31:0] addr, input logic [31:0] data);
    MemWriteM = we;
    DataAdrM  = addr;
    WriteData = data;
    @(negedge clk);
    MemWriteM = 1'b0;
    DataAdrM  = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered on the first negedge that shows the start bit; samples each bit mid-period.
  task automatic sample_frame(output logic [7:0] b, output logic p);
    repeat (2) @(negedge clk);
    check("start_bit", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
`ifdef UART_PARITY_EN
    repeat (CPB) @(negedge clk);
    p = tx;
`else
    p = 1'b0;
`endif
    repeat (CPB) @(negedge clk);
    check("stop_bit", tx, 1'b1);
  endtask

  // ---------------- scoreboard receiver ----------------
  task automatic rx_byte(input string name);
    int         waited;
    logic [7:0] b;
    logic [7:0] e;
    logic       p;
    waited = 0;
    while (tx !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check({name, "_timeout_tx"}, tx, 1'b0);
      return;
    end
    sample_frame(b, p);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got unexpected byte %0h, expected none", name, b);
    end else begin
      e = exp_q.pop_front();
      check(name, b, e);
`ifdef UART_PARITY_EN
      check({name, "_parity"}, p, ^e);
`endif
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b;
    logic       p;
    logic       saw_low;
    int         g;

    vecs[0] = '{1'b1, 32'h0000_FFF0, 8'h55, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_FFEC, 8'h41, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_FFF0, 8'h41, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h1000_FFF0, 8'h41, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_FFF0, 8'hA3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_FFF0, 8'h07, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_FFF0, 8'h03, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_FFF8, 8'h99, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h0000_FFF0, 8'h80, 1'b1, 1'b1};

    reset     = 1'b1;
    MemWriteM = 1'b0;
    DataAdrM  = 32'h0;
    WriteData = 32'h0;
    idle(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    reset = 1'b0;
    idle(2);

    // Vector table: single stores, frame contents and exact frame timing.
    for (int i = 0; i < 9; i++) begin
      store(vecs[i].we, vecs[i].addr, {24'h0, vecs[i].data});
      if (vecs[i].frame) begin
        check("tbl_count_after_push", fifo_count, 4'd1);
        check("tbl_tx_before_pop", tx, 1'b1);
        check("tbl_busy_after_push", busy, 1'b1);
        @(negedge clk);
        check("tbl_tx_fall", tx, 1'b0);
        check("tbl_count_after_pop", fifo_count, 4'd0);
        sample_frame(b, p);
        check("tbl_data", b, vecs[i].data);
`ifdef UART_PARITY_EN
        check("tbl_parity", p, vecs[i].par);
`endif
        @(negedge clk);
        check("tbl_busy_in_stop", busy, 1'b1);
        @(negedge clk);
        check("tbl_busy_drop", busy, 1'b0);
        check("tbl_tx_idle", tx, 1'b1);
      end else begin
        check("tbl_nopush_count", fifo_count, 4'd0);
        saw_low = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("tbl_nopush_tx_high", saw_low, 1'b0);
        check("tbl_nopush_busy", busy, 1'b0);
      end
      idle(2);
    end

    // Reset in the middle of a frame (during data bit 2 of 0xC3, which is 0).
    store(1'b1, 32'h0000_FFF0, 32'hC3);
    store(1'b1, 32'h0000_FFF0, 32'h3C);
    idle(13);
    check("midrst_tx_low_before", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("postrst_tx_high", saw_low, 1'b0);
    check("postrst_busy", busy, 1'b0);

    // Overflow: fill during a frame, drop the 9th, clear flag, then push on the pop edge while full.
    exp_q.push_back(8'hEE);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h5A);
    fork
      begin
        store(1'b1, 32'h0000_FFF0, 32'hEE);
        for (int i = 0; i < 9; i++) begin
          store(1'b1, 32'h0000_FFF0, 32'(i));
          if (i == 7) begin
            check("ovf_count_full", fifo_count, 4'd8);
            check("ovf_full_flag", fifo_full, 1'b1);
            check("ovf_flag_not_yet", overflow, 1'b0);
          end
        end
        check("ovf_flag_set", overflow, 1'b1);
        check("ovf_count_unchanged", fifo_count, 4'd8);
        store(1'b1, 32'h0000_FFF4, 32'h1);
        check("ovf_flag_cleared", overflow, 1'b0);
        check("ovf_count_after_clear", fifo_count, 4'd8);
        idle(4 * NB - 9);
        store(1'b1, 32'h0000_FFF0, 32'h5A);
        check("full_pushpop_count", fifo_count, 4'd8);
        check("full_pushpop_full", fifo_full, 1'b1);
      end
      begin
        for (int i = 0; i < 10; i++) rx_byte("ovf_byte");
      end
    join
    idle(4);
    check("ovf_drain_busy", busy, 1'b0);
    check("ovf_drain_count", fifo_count, 4'd0);

    // Flush: queued bytes vanish, the in-flight frame still completes.
    exp_q.push_back(8'h3C);
    fork
      rx_byte("flush_byte");
      begin
        store(1'b1, 32'h0000_FFF0, 32'h3C);
        store(1'b1, 32'h0000_FFF0, 32'h11);
        store(1'b1, 32'h0000_FFF0, 32'h22);
        check("flush_count_before", fifo_count, 4'd2);
        store(1'b1, 32'h0000_FFF4, 32'h2);
        check("flush_count_after", fifo_count, 4'd0);
        check("flush_busy_inflight", busy, 1'b1);
      end
    join
    saw_low = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("flush_no_more_frames", saw_low, 1'b0);
    check("flush_busy_end", busy, 1'b0);

    // Wrap-around: 20 bytes with random gaps, never pushing into a full FIFO.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          idle($urandom_range(0, 50));
          g = 0;
          while (fifo_full && g < 500) begin
            @(negedge clk);
            g++;
          end
          exp_q.push_back(8'hA0 + 8'(i));
          store(1'b1, 32'h0000_FFF0, {24'h0, 8'hA0 + 8'(i)});
        end
      end
      begin
        for (int i = 0; i < 20; i++) rx_byte("wrap_byte");
      end
    join
    idle(4);
    check("wrap_no_overflow", overflow, 1'b0);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_busy_end", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
